// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with enable, clamped parallel load and wrap pulse.
// Define BCD_SATURATE_EN to saturate at all 9s / all 0s instead of wrapping.
module bcd_updown_counter #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_up,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_load_val,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_tc,
   output logic                  o_wrap
);

   localparam int unsigned W = 4 * DIGITS;

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_updown_counter: DIGITS must be 1..8");
   end

   logic [W-1:0]      r_bcd;
   logic              r_wrap;

   logic [W-1:0]      w_inc;
   logic [W-1:0]      w_dec;
   logic [W-1:0]      w_load_clamped;
   logic [W-1:0]      w_bcd_d;
   logic              w_wrap_d;
   logic [DIGITS-1:0] w_is9;
   logic [DIGITS-1:0] w_is0;
   logic              w_all9;
   logic              w_all0;
   logic              w_term;

   // Per-digit increment/decrement; the carry/borrow is only live while every lower digit is 9/0.
   always_comb begin
      logic       w_carry;
      logic       w_borrow;
      logic [3:0] w_dig;
      logic [3:0] w_ld;
      w_inc          = '0;
      w_dec          = '0;
      w_load_clamped = '0;
      w_is9          = '0;
      w_is0          = '0;
      w_carry        = 1'b1;
      w_borrow       = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_dig    = r_bcd[4*i +: 4];
         w_ld     = i_load_val[4*i +: 4];
         w_is9[i] = (w_dig == 4'd9);
         w_is0[i] = (w_dig == 4'd0);

         if (!w_carry) begin
            w_inc[4*i +: 4] = w_dig;
         end else if (w_is9[i]) begin
            w_inc[4*i +: 4] = 4'd0;
         end else begin
            w_inc[4*i +: 4] = w_dig + 4'd1;
         end

         if (!w_borrow) begin
            w_dec[4*i +: 4] = w_dig;
         end else if (w_is0[i]) begin
            w_dec[4*i +: 4] = 4'd9;
         end else begin
            w_dec[4*i +: 4] = w_dig - 4'd1;
         end

         w_load_clamped[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;

         w_carry  = w_carry & w_is9[i];
         w_borrow = w_borrow & w_is0[i];
      end
   end

   assign w_all9 = &w_is9;
   assign w_all0 = &w_is0;
   assign w_term = i_up ? w_all9 : w_all0;

   // Priority: load > enable > hold.
   always_comb begin
      w_bcd_d  = r_bcd;
      w_wrap_d = 1'b0;
      if (i_load) begin
         w_bcd_d = w_load_clamped;
      end else if (i_en) begin
`ifdef BCD_SATURATE_EN
         if (!w_term) begin
            w_bcd_d = i_up ? w_inc : w_dec;
         end
`else
         w_bcd_d  = i_up ? w_inc : w_dec;
         w_wrap_d = w_term;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bcd  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_bcd  <= w_bcd_d;
         r_wrap <= w_wrap_d;
      end
   end

   assign o_bcd  = r_bcd;
   assign o_wrap = r_wrap;
   assign o_tc   = i_en & w_term;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=4 plus a DIGITS=1 instance).
module tb_bcd_updown_counter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        up;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] bcd;
   logic        tc;
   logic        wrap;

   logic        en1;
   logic        up1;
   logic        load1;
   logic [3:0]  load_val1;
   logic [3:0]  bcd1;
   logic        tc1;
   logic        wrap1;

   int checks = 0;
   int errors = 0;

   bcd_updown_counter #(.DIGITS(4)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_up       (up),
      .i_load     (load),
      .i_load_val (load_val),
      .o_bcd      (bcd),
      .o_tc       (tc),
      .o_wrap     (wrap)
   );

   bcd_updown_counter #(.DIGITS(1)) u_dut1 (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en1),
      .i_up       (up1),
      .i_load     (load1),
      .i_load_val (load_val1),
      .o_bcd      (bcd1),
      .o_tc       (tc1),
      .o_wrap     (wrap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] val);
      load     = 1'b1;
      en       = 1'b0;
      load_val = val;
      step();
      load     = 1'b0;
   endtask

   initial begin
      int wraps;
      rst_n     = 1'b0;
      en        = 1'b0;
      up        = 1'b1;
      load      = 1'b0;
      load_val  = '0;
      en1       = 1'b0;
      up1       = 1'b1;
      load1     = 1'b0;
      load_val1 = '0;

      step();
      step();
      check_eq("reset_bcd", 32'(bcd), 32'h0000);
      check_eq("reset_wrap", 32'(wrap), 32'h0);
      check_eq("reset_tc_en0", 32'(tc), 32'h0);
      #2 rst_n = 1'b1;
      step();

      // Asynchronous reset in the middle of counting.
      do_load(16'h1234);
      check_eq("load_1234", 32'(bcd), 32'h1234);
      en = 1'b1;
      up = 1'b1;
      step();
      check_eq("count_1235", 32'(bcd), 32'h1235);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_bcd", 32'(bcd), 32'h0000);
      check_eq("async_rst_wrap", 32'(wrap), 32'h0);
      en = 1'b0;
      rst_n = 1'b1;
      step();
      check_eq("hold_after_rst", 32'(bcd), 32'h0000);

      // Up ripple.
      do_load(16'h0999);
      en = 1'b1;
      up = 1'b1;
      step();
      check_eq("up_ripple_bcd", 32'(bcd), 32'h1000);
      check_eq("up_ripple_wrap", 32'(wrap), 32'h0);

      // Up wrap.
      do_load(16'h9999);
      en = 1'b1;
      up = 1'b1;
      #1;
      check_eq("up_tc_before", 32'(tc), 32'h1);
      step();
`ifdef BCD_SATURATE_EN
      check_eq("up_sat_bcd", 32'(bcd), 32'h9999);
      check_eq("up_sat_wrap", 32'(wrap), 32'h0);
`else
      check_eq("up_wrap_bcd", 32'(bcd), 32'h0000);
      check_eq("up_wrap_pulse", 32'(wrap), 32'h1);
`endif
      en = 1'b0;
      step();
      check_eq("wrap_one_cycle", 32'(wrap), 32'h0);
      check_eq("tc_en0", 32'(tc), 32'h0);

      // Down borrow.
      do_load(16'h1000);
      en = 1'b1;
      up = 1'b0;
      #1;
      check_eq("down_tc_not_term", 32'(tc), 32'h0);
      step();
      check_eq("down_borrow_bcd", 32'(bcd), 32'h0999);
      check_eq("down_borrow_wrap", 32'(wrap), 32'h0);

      // Down wrap.
      do_load(16'h0000);
      en = 1'b1;
      up = 1'b0;
      #1;
      check_eq("down_tc_before", 32'(tc), 32'h1);
      step();
`ifdef BCD_SATURATE_EN
      check_eq("down_sat_bcd", 32'(bcd), 32'h0000);
      check_eq("down_sat_wrap", 32'(wrap), 32'h0);
`else
      check_eq("down_wrap_bcd", 32'(bcd), 32'h9999);
      check_eq("down_wrap_pulse", 32'(wrap), 32'h1);
`endif

      // Load beats enable, clamps per nibble, and suppresses wrap even at terminal.
      do_load(16'h9999);
      load     = 1'b1;
      en       = 1'b1;
      up       = 1'b1;
      load_val = 16'h3FA7;
      step();
      load = 1'b0;
      en   = 1'b0;
      check_eq("prio_clamp_bcd", 32'(bcd), 32'h3997);
      check_eq("prio_clamp_wrap", 32'(wrap), 32'h0);

      // Enable gating and direction change.
      do_load(16'h0005);
      up = 1'b1;
      en = 1'b1;
      step();
      check_eq("gate_en1_a", 32'(bcd), 32'h0006);
      en = 1'b0;
      step();
      check_eq("gate_en0", 32'(bcd), 32'h0006);
      en = 1'b1;
      step();
      check_eq("gate_en1_b", 32'(bcd), 32'h0007);
      up = 1'b0;
      step();
      check_eq("dir_change_down", 32'(bcd), 32'h0006);
      en = 1'b0;

      // Single-digit instance counting continuously: wraps at edges 10 and 20.
      wraps = 0;
      en1   = 1'b1;
      up1   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (wrap1) wraps++;
      end
      en1 = 1'b0;
`ifdef BCD_SATURATE_EN
      check_eq("d1_wrap_count", 32'(wraps), 32'd0);
      check_eq("d1_final_bcd", 32'(bcd1), 32'h9);
`else
      check_eq("d1_wrap_count", 32'(wraps), 32'd2);
      check_eq("d1_final_bcd", 32'(bcd1), 32'h0);
`endif
      step();
      check_eq("d1_wrap_clear", 32'(wrap1), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
